// File: rtl/mux_lut_pkg.sv
// Shared definitions for the programmable mux-LUT gate bank.
// Holds the default table geometry, a ceil-log2 helper for counter sizing,
// the configuration state encoding and a few common 2-input truth tables.
package mux_lut_pkg;

  // Geometry of the default build (K=2 inputs, CH=4 channels).
  localparam int unsigned K_DEF    = 2;
  localparam int unsigned CH_DEF   = 4;
  localparam int unsigned T        = 1 << K_DEF;
  localparam int unsigned CFG_BITS = CH_DEF * T;

  // Smallest r with 2**r >= v (returns 0 for v <= 1).
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_LOAD = 1'b1
  } cfg_state_e;

  // Truth tables: bit i is the output for input index i.
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/mux_lut_gate_bank_mux_lut.sv
// mux_lut: one K-input programmable gate built as a binary tree of 2:1 muxes.
// Ports:
//   i_tt  [2^K-1:0]  truth table, bit i = output for select value i
//   i_sel [K-1:0]    gate inputs; bit 0 is the table-index LSB
//   o_y              selected table bit (combinational)
module mux_lut #(
  parameter int unsigned K = 2
) (
  input  logic [(1<<K)-1:0] i_tt,
  input  logic [K-1:0]      i_sel,
  output logic              o_y
);

  localparam int unsigned T = 1 << K;

  // All tree nodes in one flat vector: level 0 (the table) at [T-1:0], each
  // following level packed directly above the previous one, root at 2T-2.
  logic [2*T-2:0] w_node;

  assign w_node[T-1:0] = i_tt;

  for (genvar j = 0; j < K; j++) begin : g_level
    localparam int unsigned IN_BASE  = 2 * T - ((2 * T) >> j);
    localparam int unsigned OUT_BASE = 2 * T - ((2 * T) >> (j + 1));
    localparam int unsigned N_MUX    = T >> (j + 1);
    // Level j is steered by input bit j, so the LSB picks between leaf pairs.
    for (genvar i = 0; i < N_MUX; i++) begin : g_mux
      assign w_node[OUT_BASE+i] = i_sel[j] ? w_node[IN_BASE+2*i+1] : w_node[IN_BASE+2*i];
    end
  end

  assign o_y = w_node[2*T-2];

endmodule

// File: rtl/mux_lut_gate_bank.sv
// mux_lut_gate_bank: CH independent K-input programmable gates with a
// serially loaded, double-buffered truth-table configuration and a
// registered, valid-tracked output stage.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_cfg_valid      serial config bit strobe (always accepted)
//   i_cfg_bit        serial config data; bit n -> channel n/T, entry n%T
//   i_cfg_abort      drop a partial load (wins over i_cfg_valid)
//   o_cfg_busy       high while a load is partially accepted
//   o_cfg_done       one-cycle pulse after a new table set is committed
//   i_in_valid       input vector valid
//   i_in_data        channel c inputs at [c*K +: K]
//   o_out_valid      i_in_valid delayed by one cycle
//   o_out_data       bit c = active_table[c][channel c inputs]; holds when idle
module mux_lut_gate_bank
  import mux_lut_pkg::*;
#(
  parameter int unsigned    K        = 2,
  parameter int unsigned    CH       = 4,
  parameter logic [(1<<K)-1:0] RESET_TT = TT_NAND2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cfg_valid,
  input  logic          i_cfg_bit,
  input  logic          i_cfg_abort,
  output logic          o_cfg_busy,
  output logic          o_cfg_done,
  input  logic          i_in_valid,
  input  logic [CH*K-1:0] i_in_data,
  output logic          o_out_valid,
  output logic [CH-1:0] o_out_data
);

  localparam int unsigned TBL   = 1 << K;
  localparam int unsigned NBITS = CH * TBL;
  localparam int unsigned CNT_W = clog2(NBITS + 1);

  cfg_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic [NBITS-1:0] r_shadow;
  logic [NBITS-1:0] r_active;
  logic             r_done;
  logic             r_out_valid;
  logic [CH-1:0]    r_out_data;

  logic [NBITS-1:0] w_shadow_nxt;
  logic             w_last;
  logic [CH-1:0]    w_eval;

  // Shadow with the incoming bit inserted at the current count; on the final
  // accept this is exactly what gets committed to the active tables.
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < NBITS; i++) begin
      if (r_count == CNT_W'(i)) w_shadow_nxt[i] = i_cfg_bit;
    end
  end

  assign w_last = (r_count == CNT_W'(NBITS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= CFG_IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_active <= {CH{RESET_TT}};
      r_done   <= 1'b0;
    end else if (i_cfg_abort) begin
      r_state <= CFG_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (i_cfg_valid) begin
      r_shadow <= w_shadow_nxt;
      if (w_last) begin
        r_active <= w_shadow_nxt;
        r_state  <= CFG_IDLE;
        r_count  <= '0;
        r_done   <= 1'b1;
      end else begin
        r_state <= CFG_LOAD;
        r_count <= r_count + CNT_W'(1);
        r_done  <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    mux_lut #(
      .K(K)
    ) u_lut (
      .i_tt  (r_active[c*TBL +: TBL]),
      .i_sel (i_in_data[c*K +: K]),
      .o_y   (w_eval[c])
    );
  end

  // The active table only changes at the clock edge, so a vector sampled in
  // the commit cycle still sees the old tables.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) r_out_data <= w_eval;
    end
  end

  assign o_cfg_busy  = (r_state == CFG_LOAD);
  assign o_cfg_done  = r_done;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_mux_lut_gate_bank.sv
// Directed bench for mux_lut_gate_bank (K=2, CH=4) plus a randomised
// back-to-back check on a K=3, CH=2 build against a behavioural model.
module tb_mux_lut_gate_bank;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // K=2, CH=4 instance
  logic       rst, cfg_valid, cfg_bit, cfg_abort, in_valid;
  logic [7:0] in_data;
  logic       cfg_busy, cfg_done, out_valid;
  logic [3:0] out_data;

  // K=3, CH=2 instance
  logic       rst3, cfg_valid3, cfg_bit3, cfg_abort3, in_valid3;
  logic [5:0] in_data3;
  logic       cfg_busy3, cfg_done3, out_valid3;
  logic [1:0] out_data3;

  int n_checks = 0;
  int n_fail   = 0;

  // ch0 XOR2, ch1 AND2, ch2 all-ones, ch3 all-zeros; bit n = entry n%4 of ch n/4.
  logic [15:0] vec_mix;
  logic [15:0] vec_and;
  logic [15:0] vec_zero;

  mux_lut_gate_bank #(
    .K(2), .CH(4), .RESET_TT(4'b0111)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_bit(cfg_bit),
    .i_cfg_abort(cfg_abort), .o_cfg_busy(cfg_busy), .o_cfg_done(cfg_done),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_out_valid(out_valid),
    .o_out_data(out_data)
  );

  mux_lut_gate_bank #(
    .K(3), .CH(2), .RESET_TT(8'b0111_1111)
  ) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_cfg_valid(cfg_valid3), .i_cfg_bit(cfg_bit3),
    .i_cfg_abort(cfg_abort3), .o_cfg_busy(cfg_busy3), .o_cfg_done(cfg_done3),
    .i_in_valid(in_valid3), .i_in_data(in_data3), .o_out_valid(out_valid3),
    .o_out_data(out_data3)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick();
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL reset_out_data got %b want 0000", out_data); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", cfg_busy); end
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", cfg_done); end
  endtask

  task automatic test_nand();
    // ch0=0, ch1=1, ch2=2, ch3=3 -> NAND 1,1,1,0
    in_valid = 1'b1;
    in_data  = 8'b11_10_01_00;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nand_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 4'b0111) begin n_fail++; $display("FAIL nand_sweep got %b want 0111", out_data); end
    // Idle cycle: valid drops, data holds even though in_data changes.
    in_valid = 1'b0;
    in_data  = 8'b11_11_11_11;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 4'b0111) begin n_fail++; $display("FAIL idle_hold got %b want 0111", out_data); end
  endtask

  task automatic test_load_and_collision();
    for (int n = 0; n < 16; n++) begin
      // Last accept: present a vector that must still see the NAND tables.
      if (n == 15) begin
        in_valid = 1'b1;
        in_data  = 8'b11_11_10_01;
      end
      shift_bit(vec_mix[n]);
      if (n < 15) begin
        n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy bit %0d got %b want 1", n, cfg_busy); end
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL load_early_done bit %0d got %b want 0", n, cfg_done); end
      end
    end
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL load_done got %b want 1", cfg_done); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_end got %b want 0", cfg_busy); end
    // Old NAND: idx 1,2,3,3 -> 1,1,0,0
    n_checks++; if (out_data !== 4'b0011) begin n_fail++; $display("FAIL collision_old got %b want 0011", out_data); end
    // Same vector, new tables: XOR(1)=1, AND(2)=0, ONE=1, ZERO=0
    tick();
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", cfg_done); end
    n_checks++; if (out_data !== 4'b0101) begin n_fail++; $display("FAIL collision_new got %b want 0101", out_data); end
    // XOR(3)=0, AND(3)=1, ONE=1, ZERO=0
    in_data = 8'b00_00_11_11;
    tick();
    n_checks++; if (out_data !== 4'b0110) begin n_fail++; $display("FAIL new_tables got %b want 0110", out_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 7; n++) shift_bit(vec_zero[n]);
    n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got %b want 1", cfg_busy); end
    cfg_abort = 1'b1;
    shift_bit(1'b0);
    cfg_abort = 1'b0;
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", cfg_busy); end
    n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", cfg_done); end
    in_valid = 1'b1;
    in_data  = 8'b11_10_01_00;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 4'b0111) begin n_fail++; $display("FAIL abort_still_nand got %b want 0111", out_data); end
    // A fresh full load must commit on exactly its 16th bit.
    for (int n = 0; n < 16; n++) begin
      shift_bit(vec_mix[n]);
      if (n < 15) begin
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reload_early_done bit %0d got %b want 0", n, cfg_done); end
      end
    end
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL reload_done got %b want 1", cfg_done); end
    in_valid = 1'b1;
    in_data  = 8'b11_11_10_01;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 4'b0101) begin n_fail++; $display("FAIL reload_eval got %b want 0101", out_data); end
  endtask

  task automatic test_reset_midload();
    for (int n = 0; n < 10; n++) shift_bit(vec_zero[n]);
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 4'b0000) begin n_fail++; $display("FAIL midrst_data got %b want 0000", out_data); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", cfg_busy); end
    in_valid = 1'b1;
    in_data  = 8'b00_11_10_01;
    tick();
    in_valid = 1'b0;
    // NAND idx 1,2,3,0 -> 1,1,0,1
    n_checks++; if (out_data !== 4'b1011) begin n_fail++; $display("FAIL midrst_reset_tt got %b want 1011", out_data); end
    for (int n = 0; n < 16; n++) begin
      shift_bit(vec_and[n]);
      if (n < 15) begin
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL midrst_early_done bit %0d got %b want 0", n, cfg_done); end
      end
    end
    n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL midrst_done got %b want 1", cfg_done); end
    // All AND2: only ch1 (inputs 11) is high.
    in_valid = 1'b1;
    in_data  = 8'b10_01_11_00;
    tick();
    n_checks++; if (out_data !== 4'b0010) begin n_fail++; $display("FAIL midrst_and got %b want 0010", out_data); end
    in_data = 8'b11_11_11_11;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 4'b1111) begin n_fail++; $display("FAIL midrst_and_all got %b want 1111", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  act [2];
    logic [15:0] shadow;
    int          cnt;
    logic [1:0]  exp_data;
    logic        exp_done;
    act[0] = 8'b0111_1111;
    act[1] = 8'b0111_1111;
    shadow = '0;
    cnt    = 0;
    exp_data = 2'b00;
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid3  = (cyc < 50) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data3   = 6'($urandom);
      cfg_valid3 = (cyc < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      cfg_bit3   = 1'($urandom);
      if (in_valid3) begin
        exp_data[0] = act[0][in_data3[2:0]];
        exp_data[1] = act[1][in_data3[5:3]];
      end
      exp_done = 1'b0;
      if (cfg_valid3) begin
        shadow[cnt] = cfg_bit3;
        cnt++;
        if (cnt == 16) begin
          act[0]   = shadow[7:0];
          act[1]   = shadow[15:8];
          cnt      = 0;
          exp_done = 1'b1;
        end
      end
      tick();
      n_checks++; if (out_valid3 !== in_valid3) begin n_fail++; $display("FAIL b2b_valid cyc %0d got %b want %b", cyc, out_valid3, in_valid3); end
      n_checks++; if (out_data3 !== exp_data) begin n_fail++; $display("FAIL b2b_data cyc %0d got %b want %b", cyc, out_data3, exp_data); end
      n_checks++; if (cfg_done3 !== exp_done) begin n_fail++; $display("FAIL b2b_done cyc %0d got %b want %b", cyc, cfg_done3, exp_done); end
      n_checks++; if (cfg_busy3 !== (cnt != 0)) begin n_fail++; $display("FAIL b2b_busy cyc %0d got %b want %b", cyc, cfg_busy3, cnt != 0); end
    end
    cfg_valid3 = 1'b0;
    in_valid3  = 1'b0;
  endtask

  initial begin
    vec_mix  = 16'b0000_1111_1000_0110;
    vec_and  = 16'b1000_1000_1000_1000;
    vec_zero = 16'h0000;
    rst = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    rst3 = 1'b0; cfg_valid3 = 1'b0; cfg_bit3 = 1'b0; cfg_abort3 = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0;
    #2;
    test_reset();
    test_nand();
    test_load_and_collision();
    test_abort();
    test_reset_midload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
